// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared op codes, states, class codes,
// flag bit indices and instruction field positions.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_CMP = 4'h5,
    OP_MOV = 4'h6,
    OP_MUL = 4'h7,
    OP_SLL = 4'h8,
    OP_SLR = 4'h9,
    OP_SRL = 4'hA,
    OP_SRA = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Classes 00/01/10 are address calculations (ADD).
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam int FLG_S = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 4;

  function automatic logic is_shift(
    input logic [3:0] op
  );
    return op inside {OP_SLL, OP_SLR,
                      OP_SRL, OP_SRA};
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// alu_exec_core: combinational single-cycle ALU ops + flags.
// Ports: op, a, b in; result, flags {S,Z,C,V}, wb_en,
// illegal out. Macro ALU_EXEC_MUL_EN makes op 7 legal
// (product comes from the sequential path in the top).
module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             wb_en,
  output logic             illegal
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             v_add;
  logic             v_sub;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fv;
  logic             c;
  logic             v;
  logic             nf;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  assign v_add = (a[M] == b[M]) &&
                 (sum[M] != a[M]);
  assign v_sub = (a[M] != b[M]) &&
                 (dif[M] != a[M]);

  always_comb begin
    r       = a;
    fv      = a;
    c       = 1'b0;
    v       = 1'b0;
    nf      = 1'b0;
    wb_en   = 1'b1;
    illegal = 1'b0;
    unique case (op)
      OP_ADD: begin
        r  = sum[M:0];
        fv = sum[M:0];
        c  = sum[WIDTH];
        v  = v_add;
      end
      OP_SUB: begin
        r  = dif[M:0];
        fv = dif[M:0];
        c  = dif[WIDTH];
        v  = v_sub;
      end
      OP_CMP: begin
        // Flags of a-b, operand a passes through.
        fv    = dif[M:0];
        c     = dif[WIDTH];
        v     = v_sub;
        wb_en = 1'b0;
      end
      OP_AND: begin
        r  = a & b;
        fv = a & b;
      end
      OP_OR: begin
        r  = a | b;
        fv = a | b;
      end
      OP_XOR: begin
        r  = a ^ b;
        fv = a ^ b;
      end
      OP_MOV: begin
        r  = b;
        fv = b;
      end
      OP_MUL: begin
`ifdef ALU_EXEC_MUL_EN
        r  = a;
        fv = a;
`else
        r       = '0;
        fv      = '0;
        nf      = 1'b1;
        wb_en   = 1'b0;
        illegal = 1'b1;
`endif
      end
      // Only reached with shift amount 0.
      OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
        r  = a;
        fv = a;
      end
      default: begin
        nf    = 1'b1;
        wb_en = 1'b0;
      end
    endcase
    result = r;
    flags  = '0;
    if (!nf) begin
      flags[FLG_S] = fv[M];
      flags[FLG_Z] = (fv == '0);
      flags[FLG_C] = c;
      flags[FLG_V] = v;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execute stage, valid/ready in and out,
// single-cycle ops via alu_exec_core, bit-serial shifts.
// Ports: clk, rst_n, in_valid/in_ready, instr, a, b,
// out_valid/out_ready, result, flags {S,Z,C,V}, wb_en,
// illegal. Macro ALU_EXEC_MUL_EN adds a shift-add multiply.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             wb_en,
  output logic             illegal
);

  localparam int M = WIDTH - 1;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flg_q, flg_d;
  logic             wb_q, wb_d;
  logic             ill_q, ill_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [3:0]       dec_op;
  logic [SHW-1:0]   amt;
  logic             accept;
  logic             busy;
  logic             unused_instr;

  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flg;
  logic             core_wb;
  logic             core_ill;

  logic [3:0]       sh_op;
  logic [WIDTH-1:0] sh_in;
  logic [WIDTH:0]   sh_out;
  logic [3:0]       sh_flg;

  assign dec_op =
    (instr[CLS_HI:CLS_LO] == CLS_ALU) ?
    instr[OP_HI:OP_LO] : OP_ADD;
  assign amt    = b[SHW-1:0];
  assign busy   = (state_q == S_BUSY);

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign flags     = flg_q;
  assign wb_en     = wb_q;
  assign illegal   = ill_q;

  assign unused_instr = ^{instr[13:8], instr[3:0]};

  alu_exec_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op     (dec_op),
    .a      (a),
    .b      (b),
    .result (core_res),
    .flags  (core_flg),
    .wb_en  (core_wb),
    .illegal(core_ill)
  );

  // One-bit shifter shared by the acceptance step and BUSY.
  // sh_out = {bit shifted out, shifted value}.
  assign sh_op = busy ? op_q : dec_op;
  assign sh_in = busy ? acc_q : a;

  always_comb begin
    case (sh_op)
      OP_SLL:  sh_out = {sh_in[M], sh_in[M-1:0], 1'b0};
      OP_SLR:  sh_out = {sh_in[M], sh_in[M-1:0], sh_in[M]};
      OP_SRL:  sh_out = {sh_in[0], 1'b0, sh_in[M:1]};
      default: sh_out = {sh_in[0], sh_in[M], sh_in[M:1]};
    endcase
    sh_flg        = '0;
    sh_flg[FLG_S] = sh_out[M];
    sh_flg[FLG_Z] = (sh_out[M:0] == '0);
    sh_flg[FLG_C] = sh_out[WIDTH];
  end

`ifdef ALU_EXEC_MUL_EN
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   m_mc;
  logic [WIDTH-1:0]   m_hi;
  logic [WIDTH-1:0]   m_lo;
  logic [WIDTH:0]     m_sum;
  logic [2*WIDTH-1:0] m_out;
  logic [3:0]         mul_flg;

  // Shift-add step: add multiplicand into the high half
  // when the multiplier LSB is set, then shift right.
  assign m_mc  = busy ? mc_q : a;
  assign m_hi  = busy ? acc_q : '0;
  assign m_lo  = busy ? lo_q : b;
  assign m_sum = {1'b0, m_hi} +
                 (m_lo[0] ? {1'b0, m_mc} : '0);
  assign m_out = {m_sum, m_lo[M:1]};

  always_comb begin
    mul_flg        = '0;
    mul_flg[FLG_S] = m_out[M];
    mul_flg[FLG_Z] = (m_out[M:0] == '0);
    mul_flg[FLG_C] = |m_out[2*WIDTH-1:WIDTH];
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    acc_d   = acc_q;
    flg_d   = flg_q;
    wb_d    = wb_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
`ifdef ALU_EXEC_MUL_EN
    mc_d    = mc_q;
    lo_d    = lo_q;
`endif
    unique case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q - SHW'(1);
`ifdef ALU_EXEC_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d = m_out[2*WIDTH-1:WIDTH];
          lo_d  = m_out[M:0];
          if (cnt_q == SHW'(1)) begin
            state_d = S_DONE;
            res_d   = m_out[M:0];
            flg_d   = mul_flg;
            wb_d    = 1'b1;
            ill_d   = 1'b0;
          end
        end else
`endif
        begin
          acc_d = sh_out[M:0];
          if (cnt_q == SHW'(1)) begin
            state_d = S_DONE;
            res_d   = sh_out[M:0];
            flg_d   = sh_flg;
            wb_d    = 1'b1;
            ill_d   = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    // Acceptance overrides DONE->IDLE for back-to-back ops.
    if (accept) begin
      op_d = dec_op;
      if (is_shift(dec_op) && amt != '0) begin
        acc_d = sh_out[M:0];
        cnt_d = amt - SHW'(1);
        if (amt == SHW'(1)) begin
          state_d = S_DONE;
          res_d   = sh_out[M:0];
          flg_d   = sh_flg;
          wb_d    = 1'b1;
          ill_d   = 1'b0;
        end else begin
          state_d = S_BUSY;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      else if (dec_op == OP_MUL) begin
        acc_d   = m_out[2*WIDTH-1:WIDTH];
        lo_d    = m_out[M:0];
        mc_d    = a;
        cnt_d   = SHW'(WIDTH - 1);
        state_d = S_BUSY;
      end
`endif
      else begin
        state_d = S_DONE;
        res_d   = core_res;
        flg_d   = core_flg;
        wb_d    = core_wb;
        ill_d   = core_ill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      flg_q   <= '0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef ALU_EXEC_MUL_EN
      mc_q    <= '0;
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      flg_q   <= flg_d;
      wb_q    <= wb_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
`ifdef ALU_EXEC_MUL_EN
      mc_q    <= mc_d;
      lo_q    <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table vectors, hand sequences and
// random ops against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [15:0]   instr     = '0;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic          wb_en;
  logic          illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        wb;
    logic        ill;
    int          lat;
  } exp_t;

  typedef struct {
    string       nm;
    logic [15:0] ins;
    logic [15:0] av;
    logic [15:0] bv;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .wb_en    (wb_en),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins,
                                 input logic [15:0] av,
                                 input logic [15:0] bv);
    exp_t   e;
    longint ua, ub, sa, sb, r, fv, sr, p;
    int     op, n;
    bit     c, v, nf;
    ua = av;
    ub = bv;
    sa = $signed(av);
    sb = $signed(bv);
    op = (ins[15:14] == 2'b11) ? int'(ins[7:4]) : 0;
    n  = int'(bv[3:0]);
    r  = ua;
    fv = ua;
    c  = 0;
    v  = 0;
    nf = 0;
    e.wb  = 1'b1;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      0: begin
        r  = ua + ub;
        c  = (r >= 65536);
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
        r  = r % 65536;
      end
      1, 5: begin
        r  = (ua - ub + 65536) % 65536;
        c  = (ua < ub);
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
        fv = r;
        if (op == 5) begin
          r    = ua;
          e.wb = 1'b0;
        end
      end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      6: r = ub;
      7: begin
`ifdef ALU_EXEC_MUL_EN
        p     = ua * ub;
        r     = p % 65536;
        c     = (p >= 65536);
        e.lat = 16;
`else
        r     = 0;
        nf    = 1;
        e.wb  = 1'b0;
        e.ill = 1'b1;
`endif
      end
      8: if (n > 0) begin
        r     = (ua << n) % 65536;
        c     = ((ua >> (16 - n)) & 1) != 0;
        e.lat = n;
      end
      9: if (n > 0) begin
        r     = ((ua << n) | (ua >> (16 - n))) % 65536;
        c     = (r & 1) != 0;
        e.lat = n;
      end
      10: if (n > 0) begin
        r     = ua >> n;
        c     = ((ua >> (n - 1)) & 1) != 0;
        e.lat = n;
      end
      11: if (n > 0) begin
        r     = (sa >>> n) & 65535;
        c     = ((ua >> (n - 1)) & 1) != 0;
        e.lat = n;
      end
      default: begin
        nf   = 1;
        e.wb = 1'b0;
      end
    endcase
    if (op != 1 && op != 5) fv = r;
    e.res = r[15:0];
    if (nf) e.flg = 4'b0000;
    else e.flg = {fv[15], fv == 0, c, v};
    return e;
  endfunction

  task automatic run_op(input string nm,
                        input logic [15:0] ins,
                        input logic [15:0] av,
                        input logic [15:0] bv,
                        input exp_t e);
    int lat;
    @(negedge clk);
    instr     = ins;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    instr    = 16'($urandom);
    lat      = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, ".lat"}, lat, e.lat);
    check({nm, ".res"}, result, e.res);
    check({nm, ".flags"}, flags, e.flg);
    check({nm, ".wb"}, wb_en, e.wb);
    check({nm, ".ill"}, illegal, e.ill);
  endtask

  initial begin
    exp_t e;
    logic [15:0] ri, ra, rb;
    int cnt;

    vecs.push_back('{"add_ovf", 16'hC000, 16'h7FFF,
      16'h0001, '{16'h8000, 4'b1001, 1'b1, 1'b0, 1}});
    vecs.push_back('{"cmp_eq", 16'hC050, 16'h0005,
      16'h0005, '{16'h0005, 4'b0100, 1'b0, 1'b0, 1}});
    vecs.push_back('{"sra3", 16'hC0B0, 16'h8001,
      16'h0003, '{16'hF000, 4'b1000, 1'b1, 1'b0, 3}});
    vecs.push_back('{"sll0", 16'hC080, 16'h1234,
      16'h0010, '{16'h1234, 4'b0000, 1'b1, 1'b0, 1}});
    vecs.push_back('{"sub_brw", 16'hC010, 16'h0000,
      16'h0001, '{16'hFFFF, 4'b1010, 1'b1, 1'b0, 1}});
    vecs.push_back('{"cls00", 16'h0070, 16'hFFFF,
      16'h0001, '{16'h0000, 4'b0110, 1'b1, 1'b0, 1}});
    vecs.push_back('{"pass_e", 16'hC0E0, 16'hABCD,
      16'h1111, '{16'hABCD, 4'b0000, 1'b0, 1'b0, 1}});
    vecs.push_back('{"mov", 16'hC060, 16'h0001,
      16'h8000, '{16'h8000, 4'b1000, 1'b1, 1'b0, 1}});
    vecs.push_back('{"slr1", 16'hC090, 16'h8001,
      16'h0001, '{16'h0003, 4'b0010, 1'b1, 1'b0, 1}});
    vecs.push_back('{"srl1", 16'hC0A0, 16'h0001,
      16'h0001, '{16'h0000, 4'b0110, 1'b1, 1'b0, 1}});
    vecs.push_back('{"xor", 16'hC040, 16'hFF00,
      16'h0FF0, '{16'hF0F0, 4'b1000, 1'b1, 1'b0, 1}});
    vecs.push_back('{"add_neg", 16'hC000, 16'h8000,
      16'h8000, '{16'h0000, 4'b0111, 1'b1, 1'b0, 1}});
`ifdef ALU_EXEC_MUL_EN
    vecs.push_back('{"mul", 16'hC070, 16'h0100,
      16'h0100, '{16'h0000, 4'b0110, 1'b1, 1'b0, 16}});
`else
    vecs.push_back('{"mul_ill", 16'hC070, 16'h0100,
      16'h0100, '{16'h0000, 4'b0000, 1'b0, 1'b1, 1}});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", out_valid, 0);
    check("rst.res", result, 0);
    check("rst.flags", flags, 0);
    check("rst.wb", wb_en, 0);
    check("rst.ill", illegal, 0);
    rst_n = 1'b1;
    #1;
    check("rst.ready", in_ready, 1);

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].ins, vecs[i].av,
             vecs[i].bv, vecs[i].e);

    // Hold in DONE, then back-to-back accept
    @(negedge clk);
    instr     = 16'hC000;
    a         = 16'h7FFF;
    b         = 16'h0001;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold.valid", out_valid, 1);
      check("hold.res", result, 16'h8000);
      check("hold.flags", flags, 4'b1001);
      check("hold.ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 16'hC000;
    a         = 16'h0001;
    b         = 16'h0002;
    #1;
    check("b2b.ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b.valid", out_valid, 1);
    check("b2b.res", result, 16'h0003);
    check("b2b.flags", flags, 4'b0000);

    // Reset in the middle of a 15-step SRA
    @(negedge clk);
    instr    = 16'hC0B0;
    a        = 16'h8000;
    b        = 16'h000F;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.valid", out_valid, 0);
    check("rstmid.res", result, 0);
    check("rstmid.flags", flags, 0);
    check("rstmid.wb", wb_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid.ready", in_ready, 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rstmid.no_out", cnt, 0);
    check("rstmid.res2", result, 0);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      ri = 16'($urandom);
      if ($urandom_range(3) != 0) ri[15:14] = 2'b11;
      ra = 16'($urandom);
      rb = 16'($urandom);
      e  = model(ri, ra, rb);
      run_op($sformatf("rnd%0d_%h", i, ri), ri, ra, rb, e);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
